// File: rtl/tiny_alu_rst_pkg.sv
// Shared types and defaults for the tiny_alu reset sequencer.
package tiny_alu_rst_pkg;

   typedef enum logic [1:0] {
      RST_SYNC     = 2'd0,
      RST_HOLD     = 2'd1,
      RST_RELEASED = 2'd2
   } rst_state_e;

   localparam int unsigned RST_SYNC_STAGES_DEF = 2;
   localparam int unsigned RST_HOLD_CYCLES_DEF = 16;
   localparam int unsigned RST_COUNT_W         = 8;

   // Hold counter width; a hold of one cycle still needs a 1-bit counter
   function automatic int unsigned hold_cnt_w(input int unsigned hold);
      return (hold > 1) ? $clog2(hold) : 1;
   endfunction

endpackage

// File: rtl/tiny_alu_reset_sync.sv
// Async-assert / sync-deassert release chain for the raw board reset.
module tiny_alu_reset_sync
   import tiny_alu_rst_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = RST_SYNC_STAGES_DEF
) (
   input  logic clk_i,
   input  logic reset_n_i,
   output logic sync_rel
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sync_rel = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/tiny_alu_reset_sequencer.sv
// Conditioned ALU reset: synchronized release, programmable hold, soft reset
// requests and a saturating count of completed sequences.
module tiny_alu_reset_sequencer
   import tiny_alu_rst_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = RST_SYNC_STAGES_DEF,
   parameter int unsigned HOLD_CYCLES = RST_HOLD_CYCLES_DEF
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   soft_reset_req_i,
   output logic                   alu_reset_n_o,
   output logic                   reset_done_o,
   output logic                   busy_o,
   output logic [RST_COUNT_W-1:0] reset_count_o
);

   localparam int unsigned      CNT_W     = hold_cnt_w(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   rst_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   alu_q, alu_d;
   logic                   done_q, done_d;
   logic                   busy_q, busy_d;
   logic [RST_COUNT_W-1:0] count_q, count_d;
   logic                   sync_rel;
   logic                   entering;

   tiny_alu_reset_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .sync_rel  (sync_rel)
   );

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= RST_SYNC;
         cnt_q   <= '0;
         alu_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b1;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         alu_q   <= alu_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   // Next state and next values of every registered output
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      alu_d    = 1'b0;
      done_d   = 1'b0;
      busy_d   = 1'b1;
      count_d  = count_q;
      entering = 1'b0;

      unique case (state_q)
         RST_SYNC: begin
            if (sync_rel) begin
               state_d = RST_HOLD;
               cnt_d   = '0;
            end
         end
         RST_HOLD: begin
            // A soft request during the hold restarts it rather than stacking
            if (soft_reset_req_i) begin
               cnt_d = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = RST_RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RST_RELEASED: begin
            if (soft_reset_req_i) begin
               state_d = RST_HOLD;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = RST_SYNC;
            cnt_d   = '0;
         end
      endcase

      entering = (state_d == RST_RELEASED) && (state_q != RST_RELEASED);
      alu_d    = (state_d == RST_RELEASED);
      busy_d   = (state_d != RST_RELEASED);
      done_d   = entering;
      if (entering && (count_q != '1)) begin
         count_d = count_q + RST_COUNT_W'(1);
      end
   end

   assign alu_reset_n_o = alu_q;
   assign reset_done_o  = done_q;
   assign busy_o        = busy_q;
   assign reset_count_o = count_q;

endmodule

// File: tb/tb_tiny_alu_reset_sequencer.sv
// Bench for tiny_alu_reset_sequencer: default instance and a SYNC=3/HOLD=1
// instance, checked every cycle against an edge-count release model.
module tb_tiny_alu_reset_sequencer;

   localparam int S_A = 2;
   localparam int H_A = 16;
   localparam int S_B = 3;
   localparam int H_B = 1;

   logic       clk;
   logic       rst_v   [2];
   logic       soft_v  [2];
   logic       alu_w   [2];
   logic       done_w  [2];
   logic       busy_w  [2];
   logic [7:0] count_w [2];

   int checks = 0;
   int errors = 0;

   // Model: edges seen since reset release, edge at which alu goes high
   int e_m   [2];
   int rel_m [2];
   int cnt_m [2];
   bit done_m[2];
   int s_p   [2];
   int h_p   [2];

   tiny_alu_reset_sequencer dut_a (
      .clk_i            (clk),
      .reset_n_i        (rst_v[0]),
      .soft_reset_req_i (soft_v[0]),
      .alu_reset_n_o    (alu_w[0]),
      .reset_done_o     (done_w[0]),
      .busy_o           (busy_w[0]),
      .reset_count_o    (count_w[0])
   );

   tiny_alu_reset_sequencer #(
      .SYNC_STAGES (S_B),
      .HOLD_CYCLES (H_B)
   ) dut_b (
      .clk_i            (clk),
      .reset_n_i        (rst_v[1]),
      .soft_reset_req_i (soft_v[1]),
      .alu_reset_n_o    (alu_w[1]),
      .reset_done_o     (done_w[1]),
      .busy_o           (busy_w[1]),
      .reset_count_o    (count_w[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic reset_model(input int i);
      e_m[i]    = 0;
      rel_m[i]  = s_p[i] + h_p[i] + 1;
      cnt_m[i]  = 0;
      done_m[i] = 1'b0;
   endtask

   task automatic check(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d observed %0d expected %0d", tag, i, obs, exp);
      end
   endtask

   task automatic check_all();
      logic alu_x;
      for (int i = 0; i < 2; i++) begin
         alu_x = rst_v[i] && (e_m[i] >= rel_m[i]);
         check("alu_reset_n", i, 8'(alu_w[i]), 8'(alu_x));
         check("reset_done", i, 8'(done_w[i]), 8'(done_m[i]));
         check("busy", i, 8'(busy_w[i]), 8'(!alu_x));
         check("reset_count", i, count_w[i], 8'(cnt_m[i]));
      end
   endtask

   // Advance one clock edge, update the model from the sampled inputs, check
   task automatic step();
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         done_m[i] = 1'b0;
         if (rst_v[i]) begin
            e_m[i]++;
            // Soft requests count once the sequencer has left SYNC
            if (soft_v[i] && (e_m[i] >= s_p[i] + 2)) begin
               rel_m[i] = e_m[i] + h_p[i];
            end
            if (e_m[i] == rel_m[i]) begin
               done_m[i] = 1'b1;
               if (cnt_m[i] < 255) cnt_m[i]++;
            end
         end
      end
      #1;
      check_all();
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      s_p[0] = S_A; h_p[0] = H_A;
      s_p[1] = S_B; h_p[1] = H_B;
      for (int i = 0; i < 2; i++) begin
         rst_v[i]  = 1'b0;
         soft_v[i] = 1'b0;
         reset_model(i);
      end

      // Power-on: reset held low for five cycles, then released
      steps(5);
      rst_v[0] = 1'b1;
      rst_v[1] = 1'b1;
      steps(25);
      check("poweron_count", 0, count_w[0], 8'd1);

      // Single-cycle soft reset in RELEASED
      soft_v[0] = 1'b1;
      step();
      soft_v[0] = 1'b0;
      steps(20);
      check("soft_count", 0, count_w[0], 8'd2);

      // Soft request re-asserted five cycles into the hold
      soft_v[0] = 1'b1;
      step();
      soft_v[0] = 1'b0;
      steps(4);
      soft_v[0] = 1'b1;
      step();
      soft_v[0] = 1'b0;
      steps(25);

      // Asynchronous reset dropped between edges during the hold
      soft_v[0] = 1'b1;
      step();
      soft_v[0] = 1'b0;
      steps(7);
      @(negedge clk);
      rst_v[0] = 1'b0;
      reset_model(0);
      #1;
      check_all();
      steps(2);
      @(negedge clk);
      rst_v[0] = 1'b1;
      steps(25);

      // Sub-cycle reset glitch restarts the full sequence
      @(negedge clk);
      rst_v[0] = 1'b0;
      reset_model(0);
      #1;
      check_all();
      #2;
      rst_v[0] = 1'b1;
      steps(25);

      // Randomized soft requests on both instances
      for (int k = 0; k < 400; k++) begin
         soft_v[0] = ($urandom_range(0, 7) == 0);
         soft_v[1] = 1'($urandom_range(0, 1));
         step();
      end
      soft_v[0] = 1'b0;
      soft_v[1] = 1'b0;
      steps(20);

      // 300 soft resets on the single-cycle-hold instance saturate the count
      for (int k = 0; k < 300; k++) begin
         soft_v[1] = 1'b1;
         step();
         soft_v[1] = 1'b0;
         step();
      end
      check("count_saturated", 1, count_w[1], 8'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
